// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch request stage: forms branch/jump targets,
// holds redirects across memory waits and stalls, and parks in HALTED on halt.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_base,
    input  logic [31:0]      branch_offset_sl2,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             halt,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    // Memory handshake: a fetch completes in a cycle where imem_req and
    // imem_ready are both high and stall is low; pc is stable until then.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pend_target;
    logic             r_pend_valid;
    logic             r_halt_pend;
    logic             r_redirect;
    logic [CNT_W-1:0] r_fetch_count;

    logic             w_accept;
    logic             w_redir_now;
    logic             w_fetch_valid;
    logic [31:0]      w_branch_target;
    logic [31:0]      w_jump_target;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;

    assign w_accept        = (r_state == FETCH) && imem_ready && !stall;
    assign w_redir_now     = (jump || branch_taken) && (r_state != HALTED);
    assign w_fetch_valid   = w_accept && !r_pend_valid && !w_redir_now;
    assign w_branch_target = branch_base + branch_offset_sl2;
    assign w_jump_target   = {branch_base[31:28], jump_index, 2'b00};
    assign w_target        = jump ? w_jump_target : w_branch_target;
    assign w_pc_plus4      = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'd0;
            r_pend_valid  <= 1'b0;
            r_halt_pend   <= 1'b0;
            r_redirect    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_redirect <= w_redir_now;

            if (w_redir_now) begin
                if (w_accept) begin
                    r_pc         <= w_target;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pend_target <= w_target;
                    r_pend_valid  <= 1'b1;
                end
            end else if (w_accept) begin
                if (r_pend_valid) begin
                    r_pc         <= r_pend_target;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pc          <= w_pc_plus4;
                    r_fetch_count <= r_fetch_count + 1'b1;
                end
            end

            case (r_state)
                BOOT: begin
                    r_state <= halt ? HALTED : FETCH;
                end
                FETCH: begin
                    // The halting fetch itself still completes normally above.
                    if ((halt || r_halt_pend) && w_accept) begin
                        r_state     <= HALTED;
                        r_halt_pend <= 1'b0;
                    end else if (halt) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH);
    assign halted      = (r_state == HALTED);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = w_fetch_valid;
    assign redirect    = r_redirect;
    assign fetch_count = r_fetch_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset_sl2;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect;
    logic [31:0] fetch_count;
    logic        halted;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_base       (branch_base),
        .branch_offset_sl2 (branch_offset_sl2),
        .jump              (jump),
        .jump_index        (jump_index),
        .halt              (halt),
        .imem_ready        (imem_ready),
        .imem_req          (imem_req),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .fetch_valid       (fetch_valid),
        .redirect          (redirect),
        .fetch_count       (fetch_count),
        .halted            (halted),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_base = '0;
        branch_offset_sl2 = '0; jump = 1'b0; jump_index = '0; halt = 1'b0;
        imem_ready = 1'b1;
        #12;
        check_vec("rst_pc", pc, 32'h0);
        check_vec("rst_req", {31'd0, imem_req}, 32'd0);
        check_vec("rst_redirect", {31'd0, redirect}, 32'd0);
        check_vec("rst_count", fetch_count, 32'd0);
        check_vec("rst_halted", {31'd0, halted}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_vec("boot_req", {31'd0, imem_req}, 32'd0);

        // Sequential fetch 0,4,8,12
        step();
        check_vec("fetch_req", {31'd0, imem_req}, 32'd1);
        check_vec("fetch_pc0", pc, 32'h0);
        check_vec("fetch_fv0", {31'd0, fetch_valid}, 32'd1);
        check_vec("pc_plus4", pc_plus4, 32'h4);
        step(); check_vec("fetch_pc4", pc, 32'h4);
        step(); check_vec("fetch_pc8", pc, 32'h8);
        step(); check_vec("fetch_pc12", pc, 32'hC);
        check_vec("count3", fetch_count, 32'd3);
        step(); check_vec("fetch_pc16", pc, 32'h10);

        // Taken branch accepted in the same cycle
        branch_taken = 1'b1; branch_base = 32'h0000_000C; branch_offset_sl2 = 32'hFFFF_FFF0;
        #1; check_vec("br_fv", {31'd0, fetch_valid}, 32'd0);
        step(); branch_taken = 1'b0;
        #1;
        check_vec("br_pc", pc, 32'hFFFF_FFFC);
        check_vec("br_redirect", {31'd0, redirect}, 32'd1);
        check_vec("br_count", fetch_count, 32'd4);
        check_vec("wrap_fv", {31'd0, fetch_valid}, 32'd1);
        check_vec("wrap_plus4", pc_plus4, 32'h0);
        step();
        check_vec("wrap_pc", pc, 32'h0);
        check_vec("wrap_count", fetch_count, 32'd5);
        check_vec("redirect_pulse_end", {31'd0, redirect}, 32'd0);

        // Move to 0x20, then redirect while memory is busy
        branch_taken = 1'b1; branch_base = 32'h10; branch_offset_sl2 = 32'h10;
        step(); branch_taken = 1'b0;
        check_vec("pc20", pc, 32'h20);
        imem_ready = 1'b0; jump = 1'b1; branch_base = 32'h1000_0004; jump_index = 26'h40;
        #1; check_vec("wait_fv", {31'd0, fetch_valid}, 32'd0);
        step(); jump = 1'b0;
        check_vec("wait_pc_a", pc, 32'h20);
        check_vec("wait_redirect", {31'd0, redirect}, 32'd1);
        step();
        check_vec("wait_pc_b", pc, 32'h20);
        check_vec("wait_req", {31'd0, imem_req}, 32'd1);
        check_vec("wait_redirect_end", {31'd0, redirect}, 32'd0);
        imem_ready = 1'b1;
        #1; check_vec("pend_squash_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        check_vec("jump_pc", pc, 32'h1000_0100);
        check_vec("jump_count", fetch_count, 32'd5);
        check_vec("jump_fv", {31'd0, fetch_valid}, 32'd1);

        // Stall with jump and branch together: jump wins
        stall = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        branch_base = 32'h2000_0000; jump_index = 26'h3; branch_offset_sl2 = 32'h100;
        step(); jump = 1'b0; branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_vec("stall_pc", pc, 32'h1000_0100);
            check_vec("stall_fv", {31'd0, fetch_valid}, 32'd0);
            step();
        end
        stall = 1'b0;
        #1; check_vec("stall_rel_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        check_vec("stall_jump_pc", pc, 32'h2000_000C);
        check_vec("stall_count", fetch_count, 32'd5);

        // Halt while memory busy, then one accept, then HALTED
        imem_ready = 1'b0; halt = 1'b1;
        step(); halt = 1'b0;
        step();
        check_vec("halt_wait_pc", pc, 32'h2000_000C);
        check_vec("halt_wait_req", {31'd0, imem_req}, 32'd1);
        check_vec("halt_wait_halted", {31'd0, halted}, 32'd0);
        imem_ready = 1'b1;
        #1; check_vec("halt_acc_fv", {31'd0, fetch_valid}, 32'd1);
        step();
        check_vec("halted_pc", pc, 32'h2000_0010);
        check_vec("halted_count", fetch_count, 32'd6);
        check_vec("halted_flag", {31'd0, halted}, 32'd1);
        check_vec("halted_req", {31'd0, imem_req}, 32'd0);
        branch_taken = 1'b1; branch_base = 32'h40; branch_offset_sl2 = 32'h40;
        #1; check_vec("halted_fv", {31'd0, fetch_valid}, 32'd0);
        step(); branch_taken = 1'b0;
        check_vec("halted_br_pc", pc, 32'h2000_0010);
        check_vec("halted_br_redirect", {31'd0, redirect}, 32'd0);
        check_vec("halted_sticky", {31'd0, halted}, 32'd1);

        rst_n = 1'b0;
        #1;
        check_vec("rst2_pc", pc, 32'h0);
        check_vec("rst2_halted", {31'd0, halted}, 32'd0);
        check_vec("rst2_req", {31'd0, imem_req}, 32'd0);
        check_vec("rst2_count", fetch_count, 32'd0);
        step(); rst_n = 1'b1;
        step();
        check_vec("rst2_fetch_req", {31'd0, imem_req}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
